reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the OTTER integer register file: XLEN-wide, NREGS-deep, two asynchronous read ports, one synchronous write port, register 0 hardwired to zero.
- Adds a reset-driven clear sequencer (one register per cycle, BUSY flag), optional write-to-read bypass, and a per-register pending scoreboard for hazard detection in a pipelined OTTER.
- Sits between decode (reads, pending lookup, pending set) and writeback (write, pending clear).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2; AW = $clog2(NREGS).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show the stored value only.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  write enable.
- WA  in  AW  write address.
- WD  in  XLEN  write data.
- ADR1  in  AW  read address, port 1.
- ADR2  in  AW  read address, port 2.
- PEND_SET  in  1  mark register PEND_ADR as awaiting writeback.
- PEND_ADR  in  AW  address for PEND_SET.
- RS1  out  XLEN  read data, port 1 (combinational).
- RS2  out  XLEN  read data, port 2 (combinational).
- PEND1  out  1  pending status of ADR1 (combinational).
- PEND2  out  1  pending status of ADR2 (combinational).
- BUSY  out  1  clear sweep in progress (registered).

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Power-up initialisation: all registers 0, pend = 0, state RUN, BUSY = 0.

State machine (states CLEAR and RUN):
- Any edge with RST=1: state <- CLEAR, idx <- 0, pend[] <- 0. Register contents are not touched on these edges.
- CLEAR, RST=0: ram[idx] <- 0, idx <- idx+1. The edge that clears idx = NREGS-1 moves state to RUN.
- BUSY = (state==CLEAR). It stays 1 for exactly NREGS cycles after the first RST=0 edge, i.e. 32 cycles at the default.
- RUN: stays in RUN until RST.

While BUSY=1:
- Writes ignored.
- PEND_SET ignored.
- RS1 = RS2 = 0; PEND1 = PEND2 = 0.

Write (RUN only):
- If EN=1 and WA != 0: ram[WA] <- WD at the edge.
- Writes to WA=0 are discarded.
- ram[0] always reads 0.

Reads:
- Asynchronous; RSn = 0 if ADRn = 0, else ram[ADRn].
- Bypass (BYPASS=1): if EN=1, WA != 0, WA == ADRn and RUN, then RSn = WD in the same cycle. This holds for both ports, including both reading WA.

Scoreboard:
- Per-register bit pend[i]; pend[0] is always 0.
- PEND_SET=1 with PEND_ADR != 0: pend[PEND_ADR] <- 1.
- EN=1 with WA != 0: pend[WA] <- 0.
- Set and clear in the same cycle:
  - Same address: set wins, so the bit ends at 1 (a new producer has issued).
  - Different addresses: both take effect.
- PENDn = pend[ADRn]. With BYPASS=1 it is additionally forced 0 when a write to ADRn occurs in the same cycle.

Reset mid-sweep:
- RST=1 during CLEAR restarts the sweep at idx=0.
- BUSY stays 1 continuously.

Width rules:
- idx is AW+1 bits, or compared against NREGS-1, so there is no wrap at NREGS.
- Addresses are used unmodified; no out-of-range case exists because NREGS = 2^AW.

Test Plan:
- Reset sweep: write ram[5]=0xDEADBEEF; pulse RST 1 cycle. Require BUSY=1 for exactly 32 cycles after RST falls. An EN=1 write to x7 during the sweep is dropped. Afterwards RS1(ADR1=5)=0 and RS1(ADR1=7)=0.
- x0 protection: EN=1, WA=0, WD=0xFFFFFFFF, then ADR1=ADR2=0. Require RS1=RS2=0 and PEND1=0 after PEND_SET with PEND_ADR=0.
- Bypass: BYPASS=1, ram[3]=0x11; same cycle EN=1, WA=3, WD=0x22, ADR1=3, ADR2=3. Require RS1=RS2=0x22 combinationally, and 0x22 on the next cycle. With BYPASS=0, require 0x11 then 0x22.
- Scoreboard: PEND_SET at x9, then ADR1=9 gives PEND1=1 for 3 cycles. Write EN=1, WA=9: with BYPASS=1, PEND1=0 in the write cycle; PEND1=0 afterwards.
- Simultaneous set and clear at x4 (pend[4]=1): PEND_SET/PEND_ADR=4 with EN=1/WA=4. Require ram[4]=WD and pend[4]=1 after the edge. Same test at x4/x6: pend[4]=1 and pend[6]=0.
- Reset mid-sweep plus non-default parameters: NREGS=8, XLEN=16. Assert RST at sweep cycle 3. Require the sweep to restart, BUSY to be 1 for 8 cycles after the second RST falls, and all pend bits 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: XLEN x NREGS integer register file with two combinational read
// ports, one synchronous write port, x0 hardwired to zero, a reset-triggered
// one-register-per-cycle clear sweep, optional write-to-read forwarding, and a
// per-register pending scoreboard for hazard detection.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [AW-1:0]   WA,
    input  logic [XLEN-1:0] WD,
    input  logic [AW-1:0]   ADR1,
    input  logic [AW-1:0]   ADR2,
    input  logic            PEND_SET,
    input  logic [AW-1:0]   PEND_ADR,
    output logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] RS2,
    output logic            PEND1,
    output logic            PEND2,
    output logic            BUSY
);

    // idx carries one extra bit so the sweep counter never wraps at NREGS
    localparam int IW = AW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Power-up contents: everything zero, sequencer idle in RUN
    state_t          state = RUN;
    state_t          state_nxt;
    logic [IW-1:0]   idx = '0;
    logic [IW-1:0]   idx_nxt;
    logic [NREGS-1:0] pend = '0;
    logic [XLEN-1:0] ram [NREGS] = '{default: '0};

    logic busy;
    logic wr_req;
    logic byp_hit;

    assign busy    = (state == CLEAR);
    assign BUSY    = busy;
    // A write to x0 is never a real write, so it neither stores, clears pend nor forwards
    assign wr_req  = EN && (WA != '0);
    // Forwarding is only meaningful once the sweep is over and writes are accepted
    assign byp_hit = (BYPASS != 0) && wr_req && !busy;

    // Sequencer state and sweep index registers
    always_ff @(posedge CLK) begin
        state <= state_nxt;
        idx   <= idx_nxt;
    end

    // Next-state logic: reset (re)starts the sweep, the last index returns to RUN
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (RST) begin
            state_nxt = CLEAR;
            idx_nxt   = '0;
        end else if (state == CLEAR) begin
            idx_nxt = idx + IW'(1);
            if (idx == IW'(NREGS - 1)) begin
                state_nxt = RUN;
            end
        end
    end

    // Pending scoreboard: writeback clears, issue sets; set is applied last so it wins on a tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= '0;
        end else if (!busy) begin
            if (wr_req) begin
                pend[WA] <= 1'b0;
            end
            if (PEND_SET && (PEND_ADR != '0)) begin
                pend[PEND_ADR] <= 1'b1;
            end
        end
    end

    // Register array: sweep clears one entry per cycle, RUN accepts writes; reset edges leave it alone
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (busy) begin
                ram[idx[AW-1:0]] <= '0;
            end else if (wr_req) begin
                ram[WA] <= WD;
            end
        end
    end

    // Read ports: zero while sweeping or for x0, forwarded write data on an address match
    always_comb begin
        RS1   = '0;
        RS2   = '0;
        PEND1 = 1'b0;
        PEND2 = 1'b0;
        if (!busy) begin
            if (ADR1 != '0) begin
                RS1 = (byp_hit && (WA == ADR1)) ? WD : ram[ADR1];
            end
            if (ADR2 != '0) begin
                RS2 = (byp_hit && (WA == ADR2)) ? WD : ram[ADR2];
            end
            PEND1 = pend[ADR1] && !(byp_hit && (WA == ADR1));
            PEND2 = pend[ADR2] && !(byp_hit && (WA == ADR2));
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three register files run side by side -- default size with
// forwarding (A), default size without forwarding (B), and an 8 x 16-bit
// instance with forwarding (C). Each cycle the stimulus pushes the expected
// outputs of all three onto a queue; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_reg_file_sb;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        ps;
        logic [4:0]  pa;
    } stim_t;

    typedef struct packed {
        logic [2:0][31:0] rs1;
        logic [2:0][31:0] rs2;
        logic [2:0]       p1;
        logic [2:0]       p2;
        logic [2:0]       bz;
    } exp_t;

    stim_t s0 = '0;  // drives A and B
    stim_t s1 = '0;  // drives C

    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic [15:0] rs1_c, rs2_c;
    logic p1_a, p2_a, bz_a, p1_b, p2_b, bz_b, p1_c, p2_c, bz_c;

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
        .CLK(CLK), .RST(s0.rst), .EN(s0.en), .WA(s0.wa), .WD(s0.wd),
        .ADR1(s0.a1), .ADR2(s0.a2), .PEND_SET(s0.ps), .PEND_ADR(s0.pa),
        .RS1(rs1_a), .RS2(rs2_a), .PEND1(p1_a), .PEND2(p2_a), .BUSY(bz_a)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b (
        .CLK(CLK), .RST(s0.rst), .EN(s0.en), .WA(s0.wa), .WD(s0.wd),
        .ADR1(s0.a1), .ADR2(s0.a2), .PEND_SET(s0.ps), .PEND_ADR(s0.pa),
        .RS1(rs1_b), .RS2(rs2_b), .PEND1(p1_b), .PEND2(p2_b), .BUSY(bz_b)
    );

    reg_file_sb #(.XLEN(16), .NREGS(8), .BYPASS(1)) dut_c (
        .CLK(CLK), .RST(s1.rst), .EN(s1.en), .WA(s1.wa[2:0]), .WD(s1.wd[15:0]),
        .ADR1(s1.a1[2:0]), .ADR2(s1.a2[2:0]), .PEND_SET(s1.ps), .PEND_ADR(s1.pa[2:0]),
        .RS1(rs1_c), .RS2(rs2_c), .PEND1(p1_c), .PEND2(p2_c), .BUSY(bz_c)
    );

    // ---------------- reference model ----------------
    logic [31:0] mm   [3][32];
    logic        pm   [3][32];
    logic        mb   [3];
    int          mrem [3];

    function automatic int nr(int k);
        return (k == 2) ? 8 : 32;
    endfunction

    function automatic logic byp(int k);
        return (k != 1);
    endfunction

    function automatic logic [31:0] msk(int k);
        return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic stim_t sk(int k);
        return (k == 2) ? s1 : s0;
    endfunction

    function automatic logic [4:0] am(int k, logic [4:0] a);
        return a & 5'(nr(k) - 1);
    endfunction

    // Does a real write to address a happen this cycle (for forwarding)?
    function automatic logic fwd(int k, logic [4:0] a);
        stim_t s = sk(k);
        return byp(k) && !mb[k] && s.en && (am(k, s.wa) != 0) && (am(k, s.wa) == am(k, a));
    endfunction

    function automatic logic [31:0] exp_rs(int k, logic [4:0] a);
        if (mb[k] || am(k, a) == 0) return 32'h0;
        if (fwd(k, a)) return sk(k).wd & msk(k);
        return mm[k][am(k, a)];
    endfunction

    function automatic logic exp_pd(int k, logic [4:0] a);
        if (mb[k]) return 1'b0;
        if (fwd(k, a)) return 1'b0;
        return pm[k][am(k, a)];
    endfunction

    // Clock-edge update. Register contents are unobservable and unwritable for the
    // whole sweep, so the model treats reset as an immediate full clear plus a
    // countdown of NREGS non-reset cycles before the file becomes usable again.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            stim_t s = sk(k);
            logic [4:0] wa = am(k, s.wa);
            logic [4:0] pa = am(k, s.pa);
            if (s.rst) begin
                mb[k]   = 1'b1;
                mrem[k] = nr(k);
                for (int i = 0; i < 32; i++) begin
                    mm[k][i] = 32'h0;
                    pm[k][i] = 1'b0;
                end
            end else if (mb[k]) begin
                mrem[k]--;
                if (mrem[k] == 0) mb[k] = 1'b0;
            end else begin
                if (s.en && wa != 0) begin
                    mm[k][wa] = s.wd & msk(k);
                    pm[k][wa] = 1'b0;
                end
                if (s.ps && pa != 0) pm[k][pa] = 1'b1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, expv, $time);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("rs1",  0, rs1_a, me.rs1[0]);
            chk("rs2",  0, rs2_a, me.rs2[0]);
            chk("pend1", 0, {31'h0, p1_a}, {31'h0, me.p1[0]});
            chk("pend2", 0, {31'h0, p2_a}, {31'h0, me.p2[0]});
            chk("busy", 0, {31'h0, bz_a}, {31'h0, me.bz[0]});
            chk("rs1",  1, rs1_b, me.rs1[1]);
            chk("rs2",  1, rs2_b, me.rs2[1]);
            chk("pend1", 1, {31'h0, p1_b}, {31'h0, me.p1[1]});
            chk("pend2", 1, {31'h0, p2_b}, {31'h0, me.p2[1]});
            chk("busy", 1, {31'h0, bz_b}, {31'h0, me.bz[1]});
            chk("rs1",  2, {16'h0, rs1_c}, me.rs1[2]);
            chk("rs2",  2, {16'h0, rs2_c}, me.rs2[2]);
            chk("pend1", 2, {31'h0, p1_c}, {31'h0, me.p1[2]});
            chk("pend2", 2, {31'h0, p2_c}, {31'h0, me.p2[2]});
            chk("busy", 2, {31'h0, bz_c}, {31'h0, me.bz[2]});
        end else if (done) begin
            chk("queue_drained", 0, 32'(q.size()), 32'h0);
        end
    end

    // Issue the current inputs for one cycle: record expectations, then advance the model
    task automatic step();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.rs1[k] = exp_rs(k, sk(k).a1);
            e.rs2[k] = exp_rs(k, sk(k).a2);
            e.p1[k]  = exp_pd(k, sk(k).a1);
            e.p2[k]  = exp_pd(k, sk(k).a2);
            e.bz[k]  = mb[k];
        end
        q.push_back(e);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 3; k++) begin
            mb[k]   = 1'b0;
            mrem[k] = 0;
            for (int i = 0; i < 32; i++) begin
                mm[k][i] = 32'h0;
                pm[k][i] = 1'b0;
            end
        end
        @(posedge CLK);
        model_edge();
        #1;

        // power-up state
        s0.a1 = 5'd5; s0.a2 = 5'd31; s1.a1 = 5'd3; s1.a2 = 5'd7;
        steps(2);

        // reset sweep: x5 is cleared, a write to x7 during the sweep is dropped
        s0 = '0; s0.en = 1'b1; s0.wa = 5'd5; s0.wd = 32'hDEAD_BEEF; step();
        s0 = '0; s0.a1 = 5'd5; step();
        s0.rst = 1'b1; step();
        s0 = '0; s0.en = 1'b1; s0.wa = 5'd7; s0.wd = 32'h1234_5678; s0.a1 = 5'd7; s0.a2 = 5'd5;
        steps(6);
        s0.en = 1'b0;
        steps(30);
        s0.a1 = 5'd5; step();
        s0.a1 = 5'd7; step();

        // x0 protection
        s0 = '0; s0.en = 1'b1; s0.wa = 5'd0; s0.wd = 32'hFFFF_FFFF; step();
        s0 = '0; s0.ps = 1'b1; s0.pa = 5'd0; step();
        s0 = '0; step();

        // forwarding: x3 = 0x11, then same-cycle write of 0x22 read on both ports
        s0 = '0; s0.en = 1'b1; s0.wa = 5'd3; s0.wd = 32'h11; step();
        s0.wd = 32'h22; s0.a1 = 5'd3; s0.a2 = 5'd3; step();
        s0.en = 1'b0; steps(2);

        // scoreboard set, hold, clear by writeback
        s0 = '0; s0.ps = 1'b1; s0.pa = 5'd9; step();
        s0 = '0; s0.a1 = 5'd9; steps(3);
        s0.en = 1'b1; s0.wa = 5'd9; s0.wd = 32'h99; step();
        s0.en = 1'b0; steps(2);

        // simultaneous set/clear, same address then different addresses
        s0 = '0; s0.ps = 1'b1; s0.pa = 5'd4; s0.a1 = 5'd4; step();
        s0.en = 1'b1; s0.wa = 5'd4; s0.wd = 32'hAB; s0.a2 = 5'd4; step();
        s0.ps = 1'b0; s0.en = 1'b0; step();
        s0.ps = 1'b1; s0.pa = 5'd6; s0.a2 = 5'd6; step();
        s0.pa = 5'd4; s0.en = 1'b1; s0.wa = 5'd6; s0.wd = 32'h66; step();
        s0.ps = 1'b0; s0.en = 1'b0; steps(2);

        // small instance: populate, then reset at sweep cycle 3 and restart
        s1 = '0; s1.ps = 1'b1; s1.pa = 5'd5; s1.en = 1'b1; s1.wa = 5'd2; s1.wd = 32'hBEEF; step();
        s1 = '0; s1.a1 = 5'd5; s1.a2 = 5'd2; step();
        s1.rst = 1'b1; step();
        s1.rst = 1'b0; s1.en = 1'b1; s1.wa = 5'd2; s1.wd = 32'h7777; s1.ps = 1'b1; s1.pa = 5'd3;
        steps(3);
        s1.rst = 1'b1; step();
        s1.rst = 1'b0; steps(8);
        s1 = '0;
        for (int i = 0; i < 8; i++) begin
            s1.a1 = 5'(i); s1.a2 = 5'(7 - i); step();
        end

        // randomized traffic with clustered addresses and rare resets
        for (int n = 0; n < 3000; n++) begin
            s0.rst = ($urandom_range(0, 299) == 0);
            s0.en  = 1'($urandom_range(0, 1));
            s0.wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            s0.wd  = $urandom;
            s0.a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            s0.a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            s0.ps  = 1'($urandom_range(0, 1));
            s0.pa  = 5'($urandom_range(0, 7));
            s1.rst = ($urandom_range(0, 199) == 0);
            s1.en  = 1'($urandom_range(0, 1));
            s1.wa  = 5'($urandom_range(0, 7));
            s1.wd  = 32'($urandom_range(0, 65535));
            s1.a1  = 5'($urandom_range(0, 7));
            s1.a2  = 5'($urandom_range(0, 7));
            s1.ps  = 1'($urandom_range(0, 1));
            s1.pa  = 5'($urandom_range(0, 7));
            step();
        end

        s0 = '0;
        s1 = '0;
        done = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
